// File: rtl/pbg_pkg.sv
// Shared types and default sizing for the pattern bit generator.
package pbg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_FLUSH = 2'd2
  } pbg_state_e;

  localparam int PBG_WIDTH_DEF = 16;
  localparam int PBG_DIV_DEF   = 1;

endpackage

// File: rtl/pbg_bit_timer.sv
// Bit-period prescaler: bit_tick marks the last clock of each DIV-clock bit period.
module pbg_bit_timer
  import pbg_pkg::*;
#(
  parameter int DIV = PBG_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so every bit period starts from a full count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/pattern_bit_generator.sv
// Serialises a captured pattern MSB-first, one bit per DIV clocks, followed by a flush cycle.
// Optional looping of the captured pattern is enabled by defining PBG_REPEAT_EN.
module pattern_bit_generator
  import pbg_pkg::*;
#(
  parameter int WIDTH = PBG_WIDTH_DEF,
  parameter int DIV   = PBG_DIV_DEF,
  localparam int LW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             abort,
  input  logic             repeat_mode,
  output logic             serial_bit,
  output logic             bit_valid,
  output logic             tick_reset,
  output logic             busy,
  output logic             done,
  output pbg_state_e       state_dbg
);

  pbg_state_e       state;
  logic [WIDTH-1:0] cap_pat;
  logic [WIDTH-1:0] shreg;
  logic [LW-1:0]    cap_len;
  logic [LW-1:0]    bit_cnt;
  logic [LW-1:0]    len_eff;
  logic [WIDTH-1:0] aligned;
  logic             bit_tick;
  logic             last_bit;
  logic             loop_again;

  // Left-align the active bits so the shifter always emits from the MSB.
  assign len_eff  = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  assign aligned  = pattern << (LW'(WIDTH) - len_eff);
  assign last_bit = (bit_cnt == cap_len - 1'b1);

`ifdef PBG_REPEAT_EN
  assign loop_again = repeat_mode;
`else
  logic unused_repeat;
  assign unused_repeat = repeat_mode;
  assign loop_again    = 1'b0;
`endif

  pbg_bit_timer #(.DIV(DIV)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state == S_SEND),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cap_pat    <= '0;
      shreg      <= '0;
      cap_len    <= '0;
      bit_cnt    <= '0;
      serial_bit <= 1'b0;
      bit_valid  <= 1'b0;
      tick_reset <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tick_reset <= 1'b0;
          done       <= 1'b0;
          serial_bit <= 1'b0;
          bit_valid  <= 1'b0;
          if (start && len != '0) begin
            cap_pat    <= aligned;
            cap_len    <= len_eff;
            shreg      <= aligned << 1;
            serial_bit <= aligned[WIDTH-1];
            bit_valid  <= 1'b1;
            bit_cnt    <= '0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          // Abort wins over completion: no done pulse, only the detector clear.
          if (abort) begin
            state      <= S_IDLE;
            serial_bit <= 1'b0;
            bit_valid  <= 1'b0;
            tick_reset <= 1'b1;
            bit_cnt    <= '0;
          end else if (bit_tick) begin
            if (last_bit) begin
              state      <= S_FLUSH;
              serial_bit <= 1'b0;
              bit_valid  <= 1'b0;
              tick_reset <= 1'b1;
              done       <= 1'b1;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              serial_bit <= shreg[WIDTH-1];
              shreg      <= shreg << 1;
            end
          end
        end
        S_FLUSH: begin
          done       <= 1'b0;
          tick_reset <= 1'b0;
          bit_cnt    <= '0;
          if (abort) begin
            state      <= S_IDLE;
            tick_reset <= 1'b1;
          end else if (loop_again) begin
            state      <= S_SEND;
            shreg      <= cap_pat << 1;
            serial_bit <= cap_pat[WIDTH-1];
            bit_valid  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
